// File: rtl/lock_entry_sequencer.sv
// Sequences PIN entry for the digital lock: walks the code register index,
// compares each keypad press against the stored digit, tracks failed
// attempts, enforces lockout and bounds the unlocked window.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   button_valid   one-cycle strobe per keypad press
//   button_value   key code qualified by button_valid
//   code_length    PIN length (1..6), sampled on the first press
//   current_button code register digit at index (combinational)
//   relock         one-cycle strobe ending UNLOCKED early
//   index          digit position driven to the code register
//   unlocked       high while UNLOCKED
//   locked_out     high while LOCKOUT
//   entry_error    one-cycle pulse per failed attempt
//   attempts_left  attempts remaining before lockout
//   busy           high in ENTRY or EVAL
module lock_entry_sequencer #(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_valid,
  input  logic [3:0]          button_value,
  input  logic [2:0]          code_length,
  input  logic [3:0]          current_button,
  input  logic                relock,
  output logic [2:0]          index,
  output logic                unlocked,
  output logic                locked_out,
  output logic                entry_error,
  output logic [2:0]          attempts_left,
  output logic                busy
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned ATT_W = 3;

  localparam logic [ATT_W-1:0]   ATT_FULL     = ATT_W'(MAX_ATTEMPTS);
  localparam logic [TIMER_W-1:0] UNLOCK_LAST  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    EVAL     = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   index_nxt;
  logic [IDX_W-1:0]   len_r, len_nxt;
  logic               mismatch_r, mismatch_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [TIMER_W-1:0] timer_inc;
  logic [ATT_W-1:0]   att_nxt;
  logic               err_nxt;
  logic               digit_bad;

  // Saturating increment so a stuck terminal count never wraps to zero.
  assign timer_inc = (timer == {TIMER_W{1'b1}}) ? timer : timer + TIMER_W'(1);
  assign digit_bad = (button_value != current_button);

  // State and datapath registers; status flags are registered from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      index         <= '0;
      len_r         <= '0;
      mismatch_r    <= 1'b0;
      timer         <= '0;
      attempts_left <= ATT_FULL;
      entry_error   <= 1'b0;
      unlocked      <= 1'b0;
      locked_out    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      index         <= index_nxt;
      len_r         <= len_nxt;
      mismatch_r    <= mismatch_nxt;
      timer         <= timer_nxt;
      attempts_left <= att_nxt;
      entry_error   <= err_nxt;
      unlocked      <= (state_nxt == UNLOCKED);
      locked_out    <= (state_nxt == LOCKOUT);
      busy          <= (state_nxt == ENTRY) || (state_nxt == EVAL);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt    = state;
    index_nxt    = index;
    len_nxt      = len_r;
    mismatch_nxt = mismatch_r;
    timer_nxt    = timer;
    att_nxt      = attempts_left;
    err_nxt      = 1'b0;

    case (state)
      IDLE: begin
        index_nxt = '0;
        // Lengths 0 and 7 are invalid; such a press is simply dropped.
        if (button_valid && (code_length != 3'd0) && (code_length != 3'd7)) begin
          len_nxt      = code_length;
          mismatch_nxt = digit_bad;
          timer_nxt    = '0;
          if (code_length == 3'd1) begin
            state_nxt = EVAL;
          end else begin
            state_nxt = ENTRY;
            index_nxt = IDX_W'(1);
          end
        end
      end

      ENTRY: begin
        // A wrong digit only marks the attempt; all len_r presses are consumed.
        if (button_valid) begin
          mismatch_nxt = mismatch_r | digit_bad;
          timer_nxt    = '0;
          if (index == len_r - IDX_W'(1)) begin
            state_nxt = EVAL;
          end else begin
            index_nxt = index + IDX_W'(1);
          end
        end else if (timer == TIMEOUT_LAST) begin
          mismatch_nxt = 1'b1;
          state_nxt    = EVAL;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      EVAL: begin
        index_nxt    = '0;
        mismatch_nxt = 1'b0;
        timer_nxt    = '0;
        if (!mismatch_r) begin
          state_nxt = UNLOCKED;
          att_nxt   = ATT_FULL;
        end else begin
          err_nxt = 1'b1;
          if (attempts_left <= ATT_W'(1)) begin
            att_nxt   = '0;
            state_nxt = LOCKOUT;
          end else begin
            att_nxt   = attempts_left - ATT_W'(1);
            state_nxt = IDLE;
          end
        end
      end

      UNLOCKED: begin
        // Relock and expiry in the same cycle collapse into one exit.
        if (relock || (timer == UNLOCK_LAST)) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      LOCKOUT: begin
        if (timer == LOCKOUT_LAST) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          att_nxt   = ATT_FULL;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      default: begin
        state_nxt = IDLE;
        index_nxt = '0;
        timer_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Directed bench for lock_entry_sequencer with a small code register model
// and a scoreboard of expected attempt outcomes.
module tb_lock_entry_sequencer;

  localparam int unsigned MAX_A = 3;
  localparam int unsigned UNL   = 20;
  localparam int unsigned LOCK  = 30;
  localparam int unsigned TOUT  = 40;

  logic       clk;
  logic       rst;
  logic       button_valid;
  logic [3:0] button_value;
  logic [2:0] code_length;
  logic [3:0] current_button;
  logic       relock;
  logic [2:0] index;
  logic       unlocked;
  logic       locked_out;
  logic       entry_error;
  logic [2:0] attempts_left;
  logic       busy;

  logic [23:0] code;
  int          cb_sel;

  typedef struct packed {
    logic       unl;
    logic       err;
    logic [2:0] att;
    logic       lo;
  } res_t;

  res_t sb[$];
  int   n_cmp;
  int   n_bad;

  lock_entry_sequencer #(
    .MAX_ATTEMPTS  (MAX_A),
    .UNLOCK_CYCLES (UNL),
    .LOCKOUT_CYCLES(LOCK),
    .TIMEOUT_CYCLES(TOUT),
    .TIMER_W       (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_valid  (button_valid),
    .button_value  (button_value),
    .code_length   (code_length),
    .current_button(current_button),
    .relock        (relock),
    .index         (index),
    .unlocked      (unlocked),
    .locked_out    (locked_out),
    .entry_error   (entry_error),
    .attempts_left (attempts_left),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code register model: first digit is the most significant of the low len nibbles.
  always_comb begin
    cb_sel = int'(code_length) - 1 - int'(index);
    if (cb_sel < 0 || cb_sel > 5) current_button = 4'h0;
    else current_button = 4'(code >> (4 * cb_sel));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press is driven just after a negedge and sampled on the following posedge.
  task automatic press(input logic [3:0] v);
    button_valid = 1'b1;
    button_value = v;
    @(negedge clk);
    button_valid = 1'b0;
  endtask

  // Compare the oldest expected outcome against the DUT one edge after EVAL.
  task automatic settle();
    res_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("res_unlocked", 32'(unlocked), 32'(e.unl));
      chk("res_error", 32'(entry_error), 32'(e.err));
      chk("res_attempts", 32'(attempts_left), 32'(e.att));
      chk("res_locked_out", 32'(locked_out), 32'(e.lo));
      chk("res_index", 32'(index), 32'd0);
    end
  endtask

  task automatic entry4(input logic [15:0] digits, input res_t e);
    for (int i = 0; i < 4; i++) press(digits[15 - 4 * i -: 4]);
    sb.push_back(e);
    chk("eval_busy", 32'(busy), 32'd1);
    chk("eval_unlocked", 32'(unlocked), 32'd0);
    @(negedge clk);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b0;
    button_valid = 1'b0;
    button_value = 4'h0;
    relock       = 1'b0;
    code         = 24'h123456;
    code_length  = 3'd4;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_attempts", 32'(attempts_left), 32'd3);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_locked_out", 32'(locked_out), 32'd0);
    chk("rst_error", 32'(entry_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Correct 3456, index walk and unlock window length
    press(4'd3); chk("ok_idx1", 32'(index), 32'd1);
    press(4'd4); chk("ok_idx2", 32'(index), 32'd2);
    press(4'd5); chk("ok_idx3", 32'(index), 32'd3);
    press(4'd6);
    sb.push_back('{unl: 1'b1, err: 1'b0, att: 3'd3, lo: 1'b0});
    chk("ok_eval_idx", 32'(index), 32'd3);
    chk("ok_eval_unl", 32'(unlocked), 32'd0);
    @(negedge clk);
    settle();
    cnt = 1;
    for (int i = 0; i < int'(UNL) + 5; i++) begin
      @(negedge clk);
      if (!unlocked) break;
      cnt++;
    end
    chk("unlock_len", 32'(cnt), 32'(UNL));

    // Wrong 3956: no early abort, single error pulse
    press(4'd3); press(4'd9);
    chk("bad_idx2", 32'(index), 32'd2);
    press(4'd5);
    chk("bad_idx3", 32'(index), 32'd3);
    press(4'd6);
    sb.push_back('{unl: 1'b0, err: 1'b1, att: 3'd2, lo: 1'b0});
    @(negedge clk);
    settle();
    @(negedge clk);
    chk("err_one_cycle", 32'(entry_error), 32'd0);
    chk("bad_idle_busy", 32'(busy), 32'd0);

    // Two more failures reach lockout
    entry4(16'h1111, '{unl: 1'b0, err: 1'b1, att: 3'd1, lo: 1'b0});
    entry4(16'h3457, '{unl: 1'b0, err: 1'b1, att: 3'd0, lo: 1'b1});
    press(4'd3);
    chk("lo_press_idx", 32'(index), 32'd0);
    chk("lo_press_busy", 32'(busy), 32'd0);
    cnt = 2;
    for (int i = 0; i < int'(LOCK) + 5; i++) begin
      if (!locked_out) break;
      @(negedge clk);
      if (locked_out) cnt++;
    end
    chk("lockout_len", 32'(cnt), 32'(LOCK));
    chk("lo_done_att", 32'(attempts_left), 32'd3);
    chk("lo_done_lo", 32'(locked_out), 32'd0);

    // Correct code after lockout, relock on the 10th unlocked cycle
    entry4(16'h3456, '{unl: 1'b1, err: 1'b0, att: 3'd3, lo: 1'b0});
    repeat (9) @(negedge clk);
    chk("relock_pre", 32'(unlocked), 32'd1);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    chk("relock_drop", 32'(unlocked), 32'd0);

    // Entry timeout after two presses
    press(4'd3); press(4'd4);
    chk("to_idx", 32'(index), 32'd2);
    sb.push_back('{unl: 1'b0, err: 1'b1, att: 3'd2, lo: 1'b0});
    cnt = 0;
    for (int i = 0; i < int'(TOUT) + 10; i++) begin
      @(negedge clk);
      cnt++;
      if (entry_error) break;
    end
    chk("to_latency", 32'(cnt), 32'(TOUT + 1));
    settle();

    // Invalid length press is ignored
    code_length = 3'd0;
    press(4'd3);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_idx", 32'(index), 32'd0);
    @(negedge clk);
    chk("len0_busy2", 32'(busy), 32'd0);
    chk("len0_att", 32'(attempts_left), 32'd2);
    code_length = 3'd4;

    // Relock coinciding with unlock expiry
    entry4(16'h3456, '{unl: 1'b1, err: 1'b0, att: 3'd3, lo: 1'b0});
    repeat (UNL - 1) @(negedge clk);
    chk("both_pre", 32'(unlocked), 32'd1);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    chk("both_unl", 32'(unlocked), 32'd0);
    chk("both_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("both_stay", 32'(unlocked), 32'd0);

    // Async reset mid-entry
    entry4(16'h9999, '{unl: 1'b0, err: 1'b1, att: 3'd2, lo: 1'b0});
    press(4'd3); press(4'd4);
    chk("mid_idx", 32'(index), 32'd2);
    #3 rst = 1'b0;
    #1;
    chk("arst_idx", 32'(index), 32'd0);
    chk("arst_att", 32'(attempts_left), 32'd3);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Async reset during lockout
    entry4(16'h0000, '{unl: 1'b0, err: 1'b1, att: 3'd2, lo: 1'b0});
    entry4(16'h0000, '{unl: 1'b0, err: 1'b1, att: 3'd1, lo: 1'b0});
    entry4(16'h0000, '{unl: 1'b0, err: 1'b1, att: 3'd0, lo: 1'b1});
    repeat (5) @(negedge clk);
    chk("lo_mid", 32'(locked_out), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("arst_lo", 32'(locked_out), 32'd0);
    chk("arst_lo_att", 32'(attempts_left), 32'd3);
    chk("arst_lo_idx", 32'(index), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_entry_sequencer.md
Name: lock_entry_sequencer

Overview:
Sequences PIN entry for the digital lock.
- Drives the index input of the code register block and compares each keypad press against the current_button value it returns.
- Counts failed attempts and enforces lockout.
- Holds the unlocked state for a bounded time.
- Sits between the keypad debouncer/encoder and the lock actuator / status LEDs.

Parameters:
MAX_ATTEMPTS, 3, failed entries allowed before lockout (1..7)
UNLOCK_CYCLES, 500, cycles unlocked stays high absent relock
LOCKOUT_CYCLES, 1000, cycles locked_out stays high
TIMEOUT_CYCLES, 2000, max idle cycles between presses during entry
TIMER_W, 16, timer width; must hold the largest *_CYCLES value

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
button_valid  input  1  single-cycle strobe, one per keypad press
button_value  input  4  key code, qualified by button_valid
code_length  input  3  PIN length, valid 1..6; sampled at first press
current_button  input  4  code-register digit at the current index (combinational, same cycle)
relock  input  1  single-cycle strobe, ends UNLOCKED early
index  output  3  digit position fed to the code register, 0 = first digit
unlocked  output  1  high while in UNLOCKED
locked_out  output  1  high while in LOCKOUT
entry_error  output  1  one-cycle pulse on each failed attempt
attempts_left  output  3  remaining attempts before lockout
busy  output  1  high in ENTRY or EVAL

Behaviour:
- Reset (rst=0, async):
  - State IDLE, index=0, len_r=0, mismatch_r=0, timer=0.
  - attempts_left=MAX_ATTEMPTS; unlocked=0, locked_out=0, entry_error=0, busy=0.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- States: IDLE, ENTRY, EVAL, UNLOCKED, LOCKOUT.
- IDLE: index=0.
  - On button_valid with code_length in 1..6:
    - Latch len_r=code_length.
    - mismatch_r=(button_value!=current_button).
    - If len_r==1, go to EVAL. Otherwise go to ENTRY with index=1 and timer=0.
  - A press with code_length 0 or 7 is ignored: no state change, no attempt consumed.
- ENTRY:
  - On button_valid: mismatch_r |= (button_value!=current_button).
    - If index==len_r-1, go to EVAL.
    - Otherwise index+1 and timer=0.
  - No early abort on a wrong digit: every entry consumes exactly len_r presses.
  - Changes to code_length during entry are ignored; len_r holds.
  - Without a press, timer+1. When timer reaches TIMEOUT_CYCLES-1, force mismatch_r=1 and go to EVAL.
- EVAL (exactly 1 cycle), with index then set to 0:
  - If mismatch_r==0: go to UNLOCKED, attempts_left=MAX_ATTEMPTS, timer=0.
  - Otherwise: pulse entry_error for this cycle's transition and decrement attempts_left.
    - If the new value is 0, go to LOCKOUT with timer=0.
    - Otherwise go to IDLE.
  - mismatch_r cleared.
- UNLOCKED:
  - timer+1 each cycle. Leave to IDLE when timer==UNLOCK_CYCLES-1 or when relock=1, whichever comes first.
  - If both occur in the same cycle, go to IDLE once.
- LOCKOUT:
  - timer+1 each cycle. At LOCKOUT_CYCLES-1, go to IDLE with attempts_left=MAX_ATTEMPTS.
- button_valid is ignored in EVAL, UNLOCKED and LOCKOUT; the press is dropped, not queued. relock is ignored outside UNLOCKED.
- Latency: final correct press sampled at edge N → EVAL after N → unlocked=1 after edge N+1. entry_error follows the same timing.
- Asynchronous reset mid-entry or mid-lockout returns the block to the full reset state immediately. The attempt count is not preserved.
- index never exceeds 5. The timer saturates at its terminal count and does not wrap.

Test Plan:
- Code register loaded with code=24'h123456, code_length=4 (digits 3,4,5,6). Press 3,4,5,6 → index steps 0,1,2,3. unlocked=1 exactly 2 edges after the 4th press, for UNLOCK_CYCLES cycles. attempts_left=3.
- Same setup, press 3,9,5,6 → no early abort, index reaches 3. entry_error pulses once after the 4th press. attempts_left=2, back to IDLE.
- Three wrong 4-digit entries → attempts_left 2,1,0, then locked_out=1. Presses during LOCKOUT are ignored. After LOCKOUT_CYCLES cycles, IDLE with attempts_left=3; a correct code then unlocks.
- Press 3,4, then idle TIMEOUT_CYCLES cycles → EVAL as failure, entry_error pulses, attempts_left=2. Also press with code_length=0 → no state change.
- Unlocked, relock at cycle 10 → unlocked drops the next edge. Also relock and the timeout expiring in the same cycle → single return to IDLE.
- rst=0 asserted mid-entry at index=2 and during LOCKOUT → outputs reach reset values asynchronously (index=0, attempts_left=3, locked_out=0).
